// File: rtl/timer_entry_loader.sv
// Keypad-entry front end for the min:sec countdown timer: buffers up to four
// digits and drives the digit counters' parallel-load port. Optional macro: TIMER_ENTRY_NORMALIZE_EN.
module timer_entry_loader (
    input  logic       clk,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       cancel,
    input  logic       run,
    output logic       loadn,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] ndigits,
    output logic       err,
    output logic       pending
);

    typedef enum logic [1:0] {IDLE, ENTRY, PEND, LOAD} state_t;

    state_t          state, state_nx;
    logic [3:0][3:0] buf_q, buf_nx;      // [3]=min_tens .. [0]=sec_ones
    logic [3:0][3:0] data_q;
    logic [3:0][3:0] start_buf;
    logic [2:0]      nd_nx;
    logic            err_nx;
    logic            load_cap;
    logic            valid;

    // Validation of the buffered value, plus optional seconds-overflow fix-up.
    always_comb begin
        valid     = 1'b1;
        start_buf = buf_q;
        if (buf_q[1] > 4'd5) begin
`ifdef TIMER_ENTRY_NORMALIZE_EN
            if (buf_q[3] == 4'd9 && buf_q[2] == 4'd9) begin
                valid = 1'b0;
            end else begin
                start_buf[1] = buf_q[1] - 4'd6;
                if (buf_q[2] == 4'd9) begin
                    start_buf[2] = 4'd0;
                    start_buf[3] = buf_q[3] + 4'd1;
                end else begin
                    start_buf[2] = buf_q[2] + 4'd1;
                end
            end
`else
            valid = 1'b0;
`endif
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        buf_nx   = buf_q;
        nd_nx    = ndigits;
        err_nx   = 1'b0;
        load_cap = 1'b0;
        case (state)
            LOAD: begin
                state_nx = IDLE;
                buf_nx   = '0;
                nd_nx    = 3'd0;
            end
            PEND: begin
                if (cancel) begin
                    state_nx = IDLE;
                    buf_nx   = '0;
                    nd_nx    = 3'd0;
                end else if (!run) begin
                    state_nx = LOAD;
                    load_cap = 1'b1;
                end
            end
            IDLE, ENTRY: begin
                if (cancel) begin
                    state_nx = IDLE;
                    buf_nx   = '0;
                    nd_nx    = 3'd0;
                end else if (start) begin
                    if (state == IDLE || !valid) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                        buf_nx   = '0;
                        nd_nx    = 3'd0;
                    end else begin
                        buf_nx   = start_buf;
                        state_nx = run ? PEND : LOAD;
                        load_cap = !run;
                    end
                end else if (key_valid && key_code <= 4'd9 && ndigits < 3'd4) begin
                    buf_nx   = {buf_q[2], buf_q[1], buf_q[0], key_code};
                    nd_nx    = ndigits + 3'd1;
                    state_nx = ENTRY;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state   <= IDLE;
            buf_q   <= '0;
            data_q  <= '0;
            ndigits <= 3'd0;
            err     <= 1'b0;
            loadn   <= 1'b1;
        end else begin
            state   <= state_nx;
            buf_q   <= buf_nx;
            ndigits <= nd_nx;
            err     <= err_nx;
            loadn   <= (state_nx != LOAD);
            if (load_cap) begin
                data_q <= buf_nx;
            end
        end
    end

    // Load strobe is a flop so the counters never see a decode glitch.
    assign pending  = (state == PEND);
    assign min_tens = data_q[3];
    assign min_ones = data_q[2];
    assign sec_tens = data_q[1];
    assign sec_ones = data_q[0];

endmodule
